// File: rtl/safety_ecc_pkg.sv
// Shared types for the ECC patrol scrubber: FSM state encoding, AXI response
// codes and the counter width used by the event counters.
package safety_ecc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_WR_REQ  = 3'd4,
      ST_WR_RESP = 3'd5
   } scrub_state_e;

   // Downstream ECC reports a corrected word as EXOKAY, uncorrectable as SLVERR/DECERR.
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int CNT_WIDTH = 16;

   function automatic logic resp_is_ue(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/scrub_sat_counter.sv
// 16-bit event counter that sticks at all-ones; a synchronous clear takes
// priority over a coincident increment.
module scrub_sat_counter
   import safety_ecc_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 clr_i,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_o <= '0;
      end else if (clr_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/ecc_patrol_scrubber.sv
// Background patrol scrubber: walks base..limit reading one word per interval,
// writes corrected words back and records uncorrectable events.
module ecc_patrol_scrubber
   import safety_ecc_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    scrub_en_i,
   input  logic [ADDR_WIDTH-1:0]   base_addr_i,
   input  logic [ADDR_WIDTH-1:0]   limit_addr_i,
   input  logic [15:0]             interval_i,
   output logic [ADDR_WIDTH-1:0]   m_araddr_o,
   output logic                    m_arvalid_o,
   input  logic                    m_arready_i,
   input  logic [DATA_WIDTH-1:0]   m_rdata_i,
   input  logic [1:0]              m_rresp_i,
   input  logic                    m_rvalid_i,
   output logic                    m_rready_o,
   output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
   output logic                    m_awvalid_o,
   input  logic                    m_awready_i,
   output logic [DATA_WIDTH-1:0]   m_wdata_o,
   output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
   output logic                    m_wlast_o,
   output logic                    m_wvalid_o,
   input  logic                    m_wready_i,
   input  logic [1:0]              m_bresp_i,
   input  logic                    m_bvalid_i,
   output logic                    m_bready_o,
   output logic [15:0]             ce_count_o,
   output logic [15:0]             ue_count_o,
   output logic [ADDR_WIDTH-1:0]   ue_addr_o,
   output logic                    ue_irq_o,
   input  logic                    ue_clr_i,
   output logic                    pass_done_o,
   output logic                    busy_o,
   output scrub_state_e            dbg_state_o
);

   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

   // Handshake: a beat transfers on a rising edge with valid and ready both high;
   // every valid/ready driven here comes straight from a flop and, once raised,
   // holds with a stable payload until its transfer edge.
   scrub_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] ue_addr_q, ue_addr_d;
   logic                  ue_irq_q, ue_irq_d;
   logic                  pass_done_q, pass_done_d;
   logic                  ce_inc, ue_inc, advance;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         cnt_q       <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         araddr_q    <= '0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         ue_addr_q   <= '0;
         ue_irq_q    <= 1'b0;
         pass_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         cnt_q       <= cnt_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         araddr_q    <= araddr_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         ue_addr_q   <= ue_addr_d;
         ue_irq_q    <= ue_irq_d;
         pass_done_q <= pass_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      cnt_d       = cnt_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      araddr_d    = araddr_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      ue_addr_d   = ue_addr_q;
      ue_irq_d    = ue_irq_q;
      pass_done_d = 1'b0;
      ce_inc      = 1'b0;
      ue_inc      = 1'b0;
      advance     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (scrub_en_i) begin
               state_d    = ST_WAIT;
               cur_addr_d = base_addr_i;
               cnt_d      = interval_i;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d   = ST_RD_ADDR;
               arvalid_d = 1'b1;
               araddr_d  = cur_addr_q;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RD_ADDR: begin
            if (m_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (m_rvalid_i) begin
               rready_d = 1'b0;
               if (m_rresp_i == RESP_EXOKAY) begin
                  ce_inc    = 1'b1;
                  wdata_d   = m_rdata_i;
                  awaddr_d  = cur_addr_q;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_REQ;
               end else begin
                  ue_inc  = resp_is_ue(m_rresp_i);
                  advance = 1'b1;
               end
            end
         end
         ST_WR_REQ: begin
            // AW and W complete independently; leave only once both have gone.
            if (awvalid_q && m_awready_i) awvalid_d = 1'b0;
            if (wvalid_q && m_wready_i)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (m_bvalid_i) begin
               bready_d = 1'b0;
               ue_inc   = (m_bresp_i != RESP_OKAY);
               advance  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         cnt_d = interval_i;
         // A limit below base also lands here, so such a pass is base only.
         if (cur_addr_q >= limit_addr_i) begin
            cur_addr_d  = base_addr_i;
            pass_done_d = 1'b1;
         end else begin
            cur_addr_d = cur_addr_q + STRIDE;
         end
         state_d = scrub_en_i ? ST_WAIT : ST_IDLE;
      end

      if (ue_clr_i) begin
         ue_irq_d = 1'b0;
      end else if (ue_inc) begin
         ue_irq_d  = 1'b1;
         ue_addr_d = cur_addr_q;
      end
   end

   scrub_sat_counter u_ce_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (ue_clr_i),
      .inc_i   (ce_inc),
      .count_o (ce_count_o)
   );

   scrub_sat_counter u_ue_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (ue_clr_i),
      .inc_i   (ue_inc),
      .count_o (ue_count_o)
   );

   assign m_araddr_o  = araddr_q;
   assign m_arvalid_o = arvalid_q;
   assign m_rready_o  = rready_q;
   assign m_awaddr_o  = awaddr_q;
   assign m_awvalid_o = awvalid_q;
   assign m_wdata_o   = wdata_q;
   assign m_wstrb_o   = '1;
   assign m_wlast_o   = 1'b1;
   assign m_wvalid_o  = wvalid_q;
   assign m_bready_o  = bready_q;
   assign ue_addr_o   = ue_addr_q;
   assign ue_irq_o    = ue_irq_q;
   assign pass_done_o = pass_done_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ecc_patrol_scrubber.sv
// Directed bench for ecc_patrol_scrubber: the bench plays the AXI slave,
// expected addresses/data sit in scoreboard queues until the DUT presents them.
module tb_ecc_patrol_scrubber;
   import safety_ecc_pkg::*;

   localparam int AW = 32;
   localparam int DW = 64;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          scrub_en_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic [AW-1:0] limit_addr_i = '0;
   logic [15:0]   interval_i = '0;
   logic [AW-1:0] m_araddr_o;
   logic          m_arvalid_o;
   logic          m_arready_i = 1'b0;
   logic [DW-1:0] m_rdata_i = '0;
   logic [1:0]    m_rresp_i = '0;
   logic          m_rvalid_i = 1'b0;
   logic          m_rready_o;
   logic [AW-1:0] m_awaddr_o;
   logic          m_awvalid_o;
   logic          m_awready_i = 1'b0;
   logic [DW-1:0] m_wdata_o;
   logic [7:0]    m_wstrb_o;
   logic          m_wlast_o;
   logic          m_wvalid_o;
   logic          m_wready_i = 1'b0;
   logic [1:0]    m_bresp_i = '0;
   logic          m_bvalid_i = 1'b0;
   logic          m_bready_o;
   logic [15:0]   ce_count_o;
   logic [15:0]   ue_count_o;
   logic [AW-1:0] ue_addr_o;
   logic          ue_irq_o;
   logic          ue_clr_i = 1'b0;
   logic          pass_done_o;
   logic          busy_o;
   scrub_state_e  dbg_state_o;

   logic          sat_clr = 1'b0;
   logic          sat_inc = 1'b0;
   logic [15:0]   sat_count;

   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_awaddr_q[$];
   logic [DW-1:0] exp_wdata_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int aw_hs_cnt = 0;
   int w_hs_cnt = 0;
   int pass_cnt = 0;

   always #5 clk_i = ~clk_i;

   ecc_patrol_scrubber #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .scrub_en_i   (scrub_en_i),
      .base_addr_i  (base_addr_i),
      .limit_addr_i (limit_addr_i),
      .interval_i   (interval_i),
      .m_araddr_o   (m_araddr_o),
      .m_arvalid_o  (m_arvalid_o),
      .m_arready_i  (m_arready_i),
      .m_rdata_i    (m_rdata_i),
      .m_rresp_i    (m_rresp_i),
      .m_rvalid_i   (m_rvalid_i),
      .m_rready_o   (m_rready_o),
      .m_awaddr_o   (m_awaddr_o),
      .m_awvalid_o  (m_awvalid_o),
      .m_awready_i  (m_awready_i),
      .m_wdata_o    (m_wdata_o),
      .m_wstrb_o    (m_wstrb_o),
      .m_wlast_o    (m_wlast_o),
      .m_wvalid_o   (m_wvalid_o),
      .m_wready_i   (m_wready_i),
      .m_bresp_i    (m_bresp_i),
      .m_bvalid_i   (m_bvalid_i),
      .m_bready_o   (m_bready_o),
      .ce_count_o   (ce_count_o),
      .ue_count_o   (ue_count_o),
      .ue_addr_o    (ue_addr_o),
      .ue_irq_o     (ue_irq_o),
      .ue_clr_i     (ue_clr_i),
      .pass_done_o  (pass_done_o),
      .busy_o       (busy_o),
      .dbg_state_o  (dbg_state_o)
   );

   scrub_sat_counter u_sat (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (sat_clr),
      .inc_i   (sat_inc),
      .count_o (sat_count)
   );

   always @(posedge clk_i) begin
      if (m_awvalid_o && m_awready_i) aw_hs_cnt++;
      if (m_wvalid_o && m_wready_i)   w_hs_cnt++;
      if (pass_done_o)                pass_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ar(output int n);
      n = 0;
      while (!m_arvalid_o && n < 300) begin
         tick();
         n++;
      end
      check("ar_wait_timeout", 64'(n < 300), 64'd1);
   endtask

   task automatic serve_read(input int ar_hold, input logic [1:0] resp,
                             input logic [DW-1:0] data, input bit drop_en, output int gap);
      logic [AW-1:0] exp_a;
      int n;
      wait_ar(gap);
      exp_a = exp_q.pop_front();
      check("araddr", 64'(m_araddr_o), 64'(exp_a));
      for (int i = 0; i < ar_hold; i++) begin
         tick();
         check("araddr_hold", 64'(m_araddr_o), 64'(exp_a));
         check("arvalid_hold", 64'(m_arvalid_o), 64'd1);
      end
      m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0;
      check("arvalid_drop", 64'(m_arvalid_o), 64'd0);
      if (drop_en) scrub_en_i = 1'b0;
      m_rresp_i  = resp;
      m_rdata_i  = data;
      m_rvalid_i = 1'b1;
      n = 0;
      while (!m_rready_o && n < 50) begin
         tick();
         n++;
      end
      check("rready_timeout", 64'(n < 50), 64'd1);
      tick();
      m_rvalid_i = 1'b0;
      m_rresp_i  = 2'b00;
      m_rdata_i  = '0;
   endtask

   task automatic serve_write(input bit w_first, input logic [1:0] bresp);
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_d;
      int n;
      n = 0;
      while (!(m_awvalid_o || m_wvalid_o) && n < 50) begin
         tick();
         n++;
      end
      check("wr_timeout", 64'(n < 50), 64'd1);
      exp_a = exp_awaddr_q.pop_front();
      exp_d = exp_wdata_q.pop_front();
      check("awvalid", 64'(m_awvalid_o), 64'd1);
      check("wvalid", 64'(m_wvalid_o), 64'd1);
      check("awaddr", 64'(m_awaddr_o), 64'(exp_a));
      check("wdata", m_wdata_o, exp_d);
      check("wstrb", 64'(m_wstrb_o), 64'hFF);
      check("wlast", 64'(m_wlast_o), 64'd1);
      if (w_first) begin
         m_wready_i = 1'b1;
         tick();
         m_wready_i = 1'b0;
         check("wvalid_drop", 64'(m_wvalid_o), 64'd0);
         check("awvalid_keep", 64'(m_awvalid_o), 64'd1);
         tick();
         check("awaddr_keep", 64'(m_awaddr_o), 64'(exp_a));
         m_awready_i = 1'b1;
         tick();
         m_awready_i = 1'b0;
      end else begin
         m_awready_i = 1'b1;
         m_wready_i  = 1'b1;
         tick();
         m_awready_i = 1'b0;
         m_wready_i  = 1'b0;
      end
      check("aw_w_drop", 64'({m_awvalid_o, m_wvalid_o}), 64'd0);
      m_bresp_i  = bresp;
      m_bvalid_i = 1'b1;
      n = 0;
      while (!m_bready_o && n < 50) begin
         tick();
         n++;
      end
      check("bready_timeout", 64'(n < 50), 64'd1);
      tick();
      m_bvalid_i = 1'b0;
      m_bresp_i  = 2'b00;
   endtask

   initial begin
      int gap;
      int aw_before;
      int w_before;
      logic [DW-1:0] rnd;
      logic [AW-1:0] exp_a;

      // Reset values
      repeat (3) tick();
      check("rst_arvalid", 64'(m_arvalid_o), 64'd0);
      check("rst_rready", 64'(m_rready_o), 64'd0);
      check("rst_awvalid", 64'(m_awvalid_o), 64'd0);
      check("rst_wvalid", 64'(m_wvalid_o), 64'd0);
      check("rst_bready", 64'(m_bready_o), 64'd0);
      check("rst_ce", 64'(ce_count_o), 64'd0);
      check("rst_ue", 64'(ue_count_o), 64'd0);
      check("rst_ue_addr", 64'(ue_addr_o), 64'd0);
      check("rst_irq", 64'(ue_irq_o), 64'd0);
      check("rst_pass", 64'(pass_done_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_wlast", 64'(m_wlast_o), 64'd1);
      check("rst_wstrb", 64'(m_wstrb_o), 64'hFF);
      check("rst_araddr", 64'(m_araddr_o), 64'd0);
      check("rst_awaddr", 64'(m_awaddr_o), 64'd0);
      check("rst_wdata", m_wdata_o, 64'd0);
      check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
      rst_n_i = 1'b1;
      tick();
      check("idle_busy", 64'(busy_o), 64'd0);

      // Full pass with OKAY responses, then wrap to base
      base_addr_i  = 32'h100;
      limit_addr_i = 32'h118;
      interval_i   = 16'd2;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h108);
      exp_q.push_back(32'h110);
      exp_q.push_back(32'h118);
      exp_q.push_back(32'h100);
      scrub_en_i = 1'b1;
      rnd = {$urandom, $urandom};
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("gap_first", 64'(gap), 64'd4);
      check("busy_on", 64'(busy_o), 64'd1);
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("gap_interval", 64'(gap), 64'd3);
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("pass_cnt_mid", 64'(pass_cnt), 64'd0);
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("pass_pulse", 64'(pass_done_o), 64'd1);
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("pass_cnt_one", 64'(pass_cnt), 64'd1);

      // Corrected read at 0x108 is written back
      exp_q.push_back(32'h108);
      exp_awaddr_q.push_back(32'h108);
      exp_wdata_q.push_back(64'hDEAD_BEEF_0000_0001);
      serve_read(0, RESP_EXOKAY, 64'hDEAD_BEEF_0000_0001, 1'b0, gap);
      check("ce_one", 64'(ce_count_o), 64'd1);
      serve_write(1'b0, RESP_OKAY);
      check("aw_hs_one", 64'(aw_hs_cnt), 64'd1);
      check("w_hs_one", 64'(w_hs_cnt), 64'd1);

      // Uncorrectable read at 0x110: no write-back
      aw_before = aw_hs_cnt;
      w_before  = w_hs_cnt;
      exp_q.push_back(32'h110);
      serve_read(0, RESP_SLVERR, rnd, 1'b0, gap);
      check("ue_one", 64'(ue_count_o), 64'd1);
      check("ue_addr_110", 64'(ue_addr_o), 64'h110);
      check("ue_irq_set", 64'(ue_irq_o), 64'd1);
      check("ce_kept", 64'(ce_count_o), 64'd1);

      // Slow arready, then W accepted before AW
      rnd = {$urandom, $urandom};
      exp_q.push_back(32'h118);
      exp_awaddr_q.push_back(32'h118);
      exp_wdata_q.push_back(rnd);
      serve_read(5, RESP_EXOKAY, rnd, 1'b0, gap);
      check("no_aw_after_ue", 64'(aw_hs_cnt), 64'(aw_before));
      serve_write(1'b1, RESP_OKAY);
      check("aw_single", 64'(aw_hs_cnt), 64'(aw_before + 1));
      check("w_single", 64'(w_hs_cnt), 64'(w_before + 1));
      check("ce_two", 64'(ce_count_o), 64'd2);
      check("pass_after_wr", 64'(pass_done_o), 64'd1);

      ue_clr_i = 1'b1;
      tick();
      ue_clr_i = 1'b0;
      check("clr_ce", 64'(ce_count_o), 64'd0);
      check("clr_ue", 64'(ue_count_o), 64'd0);
      check("clr_irq", 64'(ue_irq_o), 64'd0);

      // Write response error counts as uncorrectable
      rnd = {$urandom, $urandom};
      exp_q.push_back(32'h100);
      exp_awaddr_q.push_back(32'h100);
      exp_wdata_q.push_back(rnd);
      serve_read(0, RESP_EXOKAY, rnd, 1'b0, gap);
      serve_write(1'b0, RESP_SLVERR);
      check("bresp_ue", 64'(ue_count_o), 64'd1);
      check("bresp_ue_addr", 64'(ue_addr_o), 64'h100);
      check("bresp_irq", 64'(ue_irq_o), 64'd1);
      check("bresp_ce", 64'(ce_count_o), 64'd1);

      // Clear coincident with a DECERR event: clear wins
      exp_q.push_back(32'h108);
      ue_clr_i = 1'b1;
      serve_read(0, RESP_DECERR, rnd, 1'b0, gap);
      ue_clr_i = 1'b0;
      check("clr_win_ue", 64'(ue_count_o), 64'd0);
      check("clr_win_irq", 64'(ue_irq_o), 64'd0);

      // Disable while waiting for read data
      exp_q.push_back(32'h110);
      serve_read(0, RESP_OKAY, rnd, 1'b1, gap);
      check("drop_busy", 64'(busy_o), 64'd0);
      check("drop_state", 64'(dbg_state_o), 64'(ST_IDLE));
      repeat (10) tick();
      check("drop_no_ar", 64'(m_arvalid_o), 64'd0);

      // Limit below base: every pass reads base only
      base_addr_i  = 32'h200;
      limit_addr_i = 32'h100;
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h200);
      scrub_en_i = 1'b1;
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("inv_pass", 64'(pass_done_o), 64'd1);
      serve_read(0, RESP_OKAY, rnd, 1'b0, gap);
      check("inv_gap", 64'(gap), 64'd3);
      wait_ar(gap);
      exp_a = exp_q.pop_front();
      check("inv_araddr", 64'(m_araddr_o), 64'(exp_a));

      // Reset while arvalid is up
      rst_n_i = 1'b0;
      #1;
      check("rst_mid_arvalid", 64'(m_arvalid_o), 64'd0);
      check("rst_mid_busy", 64'(busy_o), 64'd0);
      scrub_en_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      repeat (5) tick();
      check("no_resume", 64'(m_arvalid_o), 64'd0);
      check("no_resume_busy", 64'(busy_o), 64'd0);

      // Saturation of the event counter
      sat_inc = 1'b1;
      repeat (65534) tick();
      check("sat_fffe", 64'(sat_count), 64'hFFFE);
      tick();
      check("sat_ffff", 64'(sat_count), 64'hFFFF);
      repeat (5) tick();
      check("sat_hold", 64'(sat_count), 64'hFFFF);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("sat_clr_wins", 64'(sat_count), 64'd0);
      tick();
      sat_inc = 1'b0;
      check("sat_after_clr", 64'(sat_count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ecc_patrol_scrubber.md
ECC_PATROL_SCRUBBER -- requirements
Module: ecc_patrol_scrubber

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width; address stride = DATA_WIDTH/8 bytes.
REQ-003 SHALL have clk_i  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have scrub_en_i  in  1  enable patrol.
REQ-006 SHALL have base_addr_i / limit_addr_i  in  ADDR_WIDTH  first / last scrubbed word address, inclusive.
REQ-007 SHALL have interval_i  in  16  idle cycles between scrub reads.
REQ-008 SHALL have m_araddr_o, m_arvalid_o / m_arready_i  out,out/in  ADDR_WIDTH,1/1  single-beat read address.
REQ-009 SHALL have m_rdata_i, m_rresp_i, m_rvalid_i / m_rready_o  in  DATA_WIDTH,2,1 / out 1  read data (rdata already corrected downstream).
REQ-010 SHALL have m_awaddr_o, m_awvalid_o / m_awready_i; m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o / m_wready_i; m_bresp_i, m_bvalid_i / m_bready_o  write-back channels, widths per AXI4.
REQ-011 SHALL have ce_count_o / ue_count_o  out  16  corrected / uncorrectable event counts.
REQ-012 SHALL have ue_addr_o  out  ADDR_WIDTH  address of latest uncorrectable event.
REQ-013 SHALL have ue_irq_o  out  1  sticky UE flag; ue_clr_i  in  1  clears it and both counters.
REQ-014 SHALL have pass_done_o  out  1  one-cycle pulse per completed pass; busy_o  out  1  FSM not IDLE.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-016 IDLE->WAIT when scrub_en_i=1; cur_addr loads base_addr_i, interval counter loads interval_i.
REQ-017 WAIT decrements counter each cycle; at 0 -> RD_ADDR (interval_i=0: RD_ADDR next cycle).
REQ-018 RD_ADDR holds m_arvalid_o=1, m_araddr_o=cur_addr stable until m_arready_i; then RD_DATA.
REQ-019 RD_DATA drives m_rready_o=1; on m_rvalid_i: rresp=00 -> advance; 01 -> ce_count++, latch rdata, WR_REQ; 10/11 -> ue_count++, ue_addr_o=cur_addr, ue_irq_o=1, advance (no write-back).
REQ-020 WR_REQ asserts m_awvalid_o and m_wvalid_o together, m_wdata_o=latched rdata, m_wstrb_o=all ones, m_wlast_o=1; each valid drops independently on its own handshake; both done -> WR_RESP.
REQ-021 WR_RESP drives m_bready_o=1; on m_bvalid_i with bresp!=00 -> treated as UE per REQ-019; then advance.
REQ-022 Advance: cur_addr >= limit_addr_i -> cur_addr=base_addr_i, pass_done_o pulse; else cur_addr += stride; reload interval; WAIT (or IDLE if scrub_en_i=0).
REQ-023 scrub_en_i deassert mid-transaction SHALL NOT abort handshakes; FSM completes to advance then IDLE.
REQ-024 limit_addr_i < base_addr_i: every pass scrubs base_addr_i only.
REQ-025 Counters saturate at 16'hFFFF; ue_clr_i coincident with an event: clear wins, event lost.
REQ-026 All AXI valids and rready/bready SHALL be registered; no combinational ready->valid path.

Reset
REQ-027 Reset SHALL force IDLE; all valid/ready outputs 0, counters 0, ue_addr_o 0, ue_irq_o 0, pass_done_o 0, busy_o 0, m_wlast_o 1, m_wstrb_o all ones, data/addr outputs 0.
REQ-028 Reset mid-transaction SHALL drop valids immediately; no resume.

Structure
REQ-029 FSM state enum, AXI resp codes (OKAY 00, EXOKAY/CE 01, SLVERR 10) SHALL live in shared package safety_ecc_pkg.
REQ-030 Single sub-module natural: scrub_sat_counter (16-bit saturating, clear input), instanced twice.

Verification
REQ-031 base=0x100, limit=0x118, interval=2, all rresp=00 -> reads 0x100,0x108,0x110,0x118, pass_done pulse, next read 0x100.
REQ-032 rresp=01 at 0x108, rdata=0xDEAD_BEEF_0000_0001 -> AW 0x108, W same data, wstrb 0xFF; ce_count=1.
REQ-033 rresp=10 at 0x110 -> ue_count=1, ue_addr=0x110, ue_irq=1, no AW; ue_clr_i pulse -> all 0.
REQ-034 arready held 0 five cycles -> araddr/arvalid stable; awready after wready -> single AW, single W.
REQ-035 scrub_en_i=0 during RD_DATA -> transaction completes, IDLE, busy_o=0; 0x10000 CE events -> ce_count=0xFFFF.
